// File: rtl/lsu_if.sv
// Request/response and DMEM port bundle for the load/store unit.
// slave = the lsu side, master = requester + DMEM side.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [29:0] mem_A;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_we, mem_wmask, mem_A, mem_wd
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_we, mem_wmask, mem_A, mem_wd
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one request at a time, drives DMEM word port, splits
// word-straddling accesses into two word accesses, aligns/extends loads.
module lsu (
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
  } req_t;

  state_t      state, state_nxt;
  req_t        rq;
  logic [31:0] lo, hi;
  logic [29:0] a_last;   // mem_A is held here between accesses

  logic        illegal_in;
  logic [1:0]  off;
  logic [3:0]  size_mask;
  logic [2:0]  size;
  logic [7:0]  lane_m;
  logic [63:0] lane_d;
  logic        split;
  logic [29:0] word_a;
  logic [31:0] x;
  logic [31:0] result;

  // Only B/H/W stores and B/H/W/BU/HU loads are legal.
  assign illegal_in = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11) ||
                      (bus.req_funct3[2] && bus.req_we);

  // Lane mask/data for the 8-byte window spanning this word and the next.
  always_comb begin
    off       = rq.addr[1:0];
    word_a    = rq.addr[31:2];
    size_mask = 4'b1111;
    size      = 3'd4;
    case (rq.funct3[1:0])
      2'b00:   begin size_mask = 4'b0001; size = 3'd1; end
      2'b01:   begin size_mask = 4'b0011; size = 3'd2; end
      default: begin size_mask = 4'b1111; size = 3'd4; end
    endcase
    lane_m = {4'b0000, size_mask} << off;
    lane_d = {32'h0, rq.wdata} << {off, 3'b000};
    split  = ({1'b0, off} + size) > 3'd4;
    x      = 32'({(split ? hi : 32'h0), lo} >> {off, 3'b000});
    case (rq.funct3)
      3'b000:  result = {{24{x[7]}}, x[7:0]};
      3'b001:  result = {{16{x[15]}}, x[15:0]};
      3'b100:  result = {24'h0, x[7:0]};
      3'b101:  result = {16'h0, x[15:0]};
      default: result = x;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request capture, load data capture and last-address hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq     <= '0;
      lo     <= '0;
      hi     <= '0;
      a_last <= '0;
    end else begin
      if (state == IDLE && bus.req_valid)
        rq <= '{we: bus.req_we, funct3: bus.req_funct3, addr: bus.req_addr,
                wdata: bus.req_wdata, err: illegal_in};
      if (state == ACC0 && !rq.we) lo <= bus.mem_rd;
      if (state == ACC1 && !rq.we) hi <= bus.mem_rd;
      if (state == ACC0 || state == ACC1) a_last <= bus.mem_A;
    end
  end

  // Next state and all outputs.
  always_comb begin
    state_nxt      = state;
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 32'h0;
    bus.resp_err   = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_wmask  = 4'b0000;
    bus.mem_wd     = 32'h0;
    bus.mem_A      = a_last;
    case (state)
      IDLE: if (bus.req_valid) state_nxt = illegal_in ? RESP : ACC0;
      ACC0: begin
        bus.mem_A     = word_a;
        bus.mem_wmask = lane_m[3:0];
        bus.mem_wd    = lane_d[31:0];
        bus.mem_we    = rq.we;
        state_nxt     = split ? ACC1 : RESP;
      end
      ACC1: begin
        bus.mem_A     = word_a + 30'd1;
        bus.mem_wmask = lane_m[7:4];
        bus.mem_wd    = lane_d[63:32];
        bus.mem_we    = rq.we;
        state_nxt     = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = rq.err;
        bus.resp_rdata = (rq.we || rq.err) ? 32'h0 : result;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a 256-word byte-masked DMEM model.
module tb_lsu;
  logic clk = 1'b0;
  logic rst;
  lsu_if bus();

  lsu dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // DMEM model: combinational read, byte-masked write on the rising edge.
  logic [31:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  assign bus.mem_rd = mem[bus.mem_A[7:0]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (bus.mem_we)
      for (int b = 0; b < 4; b++)
        if (bus.mem_wmask[b]) mem[bus.mem_A[7:0]][8*b +: 8] <= bus.mem_wd[8*b +: 8];
  end

  int total = 0;
  int bad   = 0;

  // Per-transaction observations gathered by issue().
  int          lat;
  logic [29:0] s_a  [4];
  logic        s_we [4];
  logic [3:0]  s_mk [4];
  logic [31:0] s_wd [4];
  logic [31:0] r_data;
  logic        r_err;
  logic        any_we;

  task automatic preload(input logic [7:0] idx, input logic [31:0] d);
    pl_en = 1'b1; pl_idx = idx; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Drives one request from IDLE, records ACC cycles, waits (bounded) for
  // resp_valid, then steps through the RESP cycle back to IDLE.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr;  bus.req_wdata = wd;
    any_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_a[i] = '0; s_we[i] = 1'b0; s_mk[i] = '0; s_wd[i] = '0;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 8) begin
      if (lat < 4) begin
        s_a[lat] = bus.mem_A; s_we[lat] = bus.mem_we;
        s_mk[lat] = bus.mem_wmask; s_wd[lat] = bus.mem_wd;
      end
      any_we = any_we | bus.mem_we;
      @(posedge clk); #1;
      lat++;
    end
    r_data = bus.resp_rdata;
    r_err  = bus.resp_err;
    any_we = any_we | bus.mem_we;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", bus.req_ready); end
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", bus.resp_valid); end
    total++; if (bus.resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", bus.resp_rdata); end
    total++; if (bus.resp_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.resp_err); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
    total++; if (bus.mem_wmask !== 4'h0) begin bad++; $display("FAIL rst_wmask got=%b exp=0000", bus.mem_wmask); end
    total++; if (bus.mem_A !== 30'h0) begin bad++; $display("FAIL rst_mem_A got=%h exp=0", bus.mem_A); end
    total++; if (bus.mem_wd !== 32'h0) begin bad++; $display("FAIL rst_mem_wd got=%h exp=0", bus.mem_wd); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_aligned_lw();
    preload(8'd25, 32'h84755779);
    issue(1'b0, 3'b010, 32'h64, 32'h0);
    total++; if (s_a[1] !== 30'd25) begin bad++; $display("FAIL lw_mem_A got=%0d exp=25", s_a[1]); end
    total++; if (s_we[1] !== 1'b0) begin bad++; $display("FAIL lw_mem_we got=%b exp=0", s_we[1]); end
    total++; if (lat !== 2) begin bad++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    total++; if (r_data !== 32'h84755779) begin bad++; $display("FAIL lw_rdata got=%h exp=84755779", r_data); end
    total++; if (r_err !== 1'b0) begin bad++; $display("FAIL lw_err got=%b exp=0", r_err); end
  endtask

  task automatic test_byte_loads();
    logic [2:0]  f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001};
    logic [31:0] ad  [5] = '{32'h67, 32'h67, 32'h64, 32'h66, 32'h66};
    logic [31:0] exp [5] = '{32'hFFFFFF84, 32'h00000084, 32'h00005779, 32'h00008475, 32'hFFFF8475};
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, f3[i], ad[i], 32'h0);
      total++; if (r_data !== exp[i] || lat !== 2)
        begin bad++; $display("FAIL subword_load_%0d got=%h lat=%0d exp=%h lat=2", i, r_data, lat, exp[i]); end
    end
  endtask

  task automatic test_store_half();
    issue(1'b1, 3'b001, 32'h66, 32'h1234BEEF);
    total++; if (s_a[1] !== 30'd25) begin bad++; $display("FAIL sh_mem_A got=%0d exp=25", s_a[1]); end
    total++; if (s_we[1] !== 1'b1) begin bad++; $display("FAIL sh_mem_we got=%b exp=1", s_we[1]); end
    total++; if (s_mk[1] !== 4'b1100) begin bad++; $display("FAIL sh_wmask got=%b exp=1100", s_mk[1]); end
    total++; if (s_wd[1] !== 32'hBEEF0000) begin bad++; $display("FAIL sh_wd got=%h exp=beef0000", s_wd[1]); end
    total++; if (lat !== 2 || r_data !== 32'h0) begin bad++; $display("FAIL sh_resp got lat=%0d rdata=%h exp lat=2 rdata=0", lat, r_data); end
    total++; if (mem[25] !== 32'hBEEF5779) begin bad++; $display("FAIL sh_mem_word got=%h exp=beef5779", mem[25]); end
    issue(1'b0, 3'b010, 32'h64, 32'h0);
    total++; if (r_data !== 32'hBEEF5779) begin bad++; $display("FAIL sh_readback got=%h exp=beef5779", r_data); end
  endtask

  task automatic test_split();
    preload(8'd3, 32'h0);
    preload(8'd4, 32'h0);
    issue(1'b1, 3'b010, 32'h0F, 32'h11223344);
    total++; if (s_a[1] !== 30'd3 || s_mk[1] !== 4'b1000 || s_wd[1] !== 32'h44000000)
      begin bad++; $display("FAIL split_acc0 got A=%0d mk=%b wd=%h exp A=3 mk=1000 wd=44000000", s_a[1], s_mk[1], s_wd[1]); end
    total++; if (s_a[2] !== 30'd4 || s_mk[2] !== 4'b0111 || s_wd[2] !== 32'h00112233)
      begin bad++; $display("FAIL split_acc1 got A=%0d mk=%b wd=%h exp A=4 mk=0111 wd=00112233", s_a[2], s_mk[2], s_wd[2]); end
    total++; if (s_we[1] !== 1'b1 || s_we[2] !== 1'b1) begin bad++; $display("FAIL split_we got=%b%b exp=11", s_we[1], s_we[2]); end
    total++; if (lat !== 3) begin bad++; $display("FAIL split_sw_latency got=%0d exp=3", lat); end
    total++; if (mem[3] !== 32'h44000000 || mem[4] !== 32'h00112233)
      begin bad++; $display("FAIL split_mem got=%h/%h exp=44000000/00112233", mem[3], mem[4]); end
    issue(1'b0, 3'b010, 32'h0F, 32'h0);
    total++; if (r_data !== 32'h11223344 || lat !== 3)
      begin bad++; $display("FAIL split_lw got=%h lat=%0d exp=11223344 lat=3", r_data, lat); end
    issue(1'b0, 3'b001, 32'h0F, 32'h0);
    total++; if (r_data !== 32'h00003344 || lat !== 3)
      begin bad++; $display("FAIL split_lh got=%h lat=%0d exp=00003344 lat=3", r_data, lat); end
  endtask

  task automatic test_illegal();
    logic        we  [3] = '{1'b0, 1'b1, 1'b1};
    logic [2:0]  f3  [3] = '{3'b011, 3'b100, 3'b110};
    for (int i = 0; i < 3; i++) begin
      issue(we[i], f3[i], 32'h64, 32'hFFFFFFFF);
      total++; if (lat !== 1 || r_err !== 1'b1 || r_data !== 32'h0)
        begin bad++; $display("FAIL illegal_%0d got lat=%0d err=%b rdata=%h exp lat=1 err=1 rdata=0", i, lat, r_err, r_data); end
      total++; if (any_we !== 1'b0) begin bad++; $display("FAIL illegal_we_%0d got=%b exp=0", i, any_we); end
    end
    total++; if (bus.resp_err !== 1'b0) begin bad++; $display("FAIL err_idle got=%b exp=0", bus.resp_err); end
    total++; if (mem[25] !== 32'hBEEF5779) begin bad++; $display("FAIL illegal_mem got=%h exp=beef5779", mem[25]); end
  endtask

  task automatic test_wrap();
    preload(8'd255, 32'hAABBCCDD);
    preload(8'd0, 32'h11223344);
    issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
    total++; if (s_a[1] !== 30'h3FFFFFFF) begin bad++; $display("FAIL wrap_acc0_A got=%h exp=3fffffff", s_a[1]); end
    total++; if (s_a[2] !== 30'h0) begin bad++; $display("FAIL wrap_acc1_A got=%h exp=0", s_a[2]); end
    total++; if (lat !== 3 || r_data !== 32'h3344AABB)
      begin bad++; $display("FAIL wrap_lw got=%h lat=%0d exp=3344aabb lat=3", r_data, lat); end
    total++; if (bus.mem_A !== 30'h0) begin bad++; $display("FAIL mem_A_hold got=%h exp=0", bus.mem_A); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] pv, pr;
    logic       okd;
    pv = '0; pr = '0; okd = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h64; bus.req_wdata = 32'h0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      pv[i] = bus.resp_valid;
      pr[i] = bus.req_ready;
      if (bus.resp_valid === 1'b1 && bus.resp_rdata !== 32'hBEEF5779) okd = 1'b0;
    end
    bus.req_valid = 1'b0;
    total++; if (pv !== 9'b010010010) begin bad++; $display("FAIL b2b_resp_pattern got=%b exp=010010010", pv); end
    total++; if (pr !== 9'b100100100) begin bad++; $display("FAIL b2b_ready_pattern got=%b exp=100100100", pr); end
    total++; if (okd !== 1'b1) begin bad++; $display("FAIL b2b_rdata got=%b exp=1", okd); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    preload(8'd7, 32'h000000EE);
    preload(8'd8, 32'h55555555);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h1D; bus.req_wdata = 32'hA1B2C3D4;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    total++; if (bus.mem_A !== 30'd7 || bus.mem_wmask !== 4'b1110 || bus.mem_wd !== 32'hB2C3D400)
      begin bad++; $display("FAIL rmid_acc0 got A=%0d mk=%b wd=%h exp A=7 mk=1110 wd=b2c3d400", bus.mem_A, bus.mem_wmask, bus.mem_wd); end
    @(posedge clk); #1;
    total++; if (bus.mem_A !== 30'd8 || bus.mem_wmask !== 4'b0001 || bus.mem_we !== 1'b1)
      begin bad++; $display("FAIL rmid_acc1 got A=%0d mk=%b we=%b exp A=8 mk=0001 we=1", bus.mem_A, bus.mem_wmask, bus.mem_we); end
    rst = 1'b1;
    #1;
    total++; if (bus.mem_we !== 1'b0 || bus.mem_wmask !== 4'h0 || bus.mem_A !== 30'h0 || bus.mem_wd !== 32'h0)
      begin bad++; $display("FAIL rmid_async_mem got we=%b mk=%b A=%h wd=%h exp all 0", bus.mem_we, bus.mem_wmask, bus.mem_A, bus.mem_wd); end
    total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h0)
      begin bad++; $display("FAIL rmid_async_resp got rdy=%b vld=%b err=%b rd=%h exp 1/0/0/0", bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", bus.req_ready); end
    total++; if (mem[7] !== 32'hB2C3D4EE) begin bad++; $display("FAIL rmid_acc0_word got=%h exp=b2c3d4ee", mem[7]); end
    total++; if (mem[8] !== 32'h55555555) begin bad++; $display("FAIL rmid_acc1_word got=%h exp=55555555", mem[8]); end
  endtask

  initial begin
    rst = 1'b1;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0;
    test_reset();
    test_aligned_lw();
    test_byte_loads();
    test_store_half();
    test_split();
    test_illegal();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
